// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: writeback select, MEM-stage states, latched request payload.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LUI  = 2'b10,
    WB_LINK = 2'b11
  } wbsel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    HALTED = 2'b10
  } memstate_t;

  // Everything the MEM stage must remember while a cache miss is outstanding
  typedef struct packed {
    logic              is_store;
    logic              regwr;
    logic [REG_W-1:0]  regdst;
    wbsel_t            memtoreg;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] store;
    logic [WORD_W-1:0] lui;
    logic [WORD_W-1:0] pcp4;
  } mem_req_t;

  function automatic logic [WORD_W-1:0] wb_select(
    input wbsel_t            sel,
    input logic [WORD_W-1:0] alu,
    input logic [WORD_W-1:0] load,
    input logic [WORD_W-1:0] lui,
    input logic [WORD_W-1:0] link
  );
    unique case (sel)
      WB_ALU:  wb_select = alu;
      WB_LOAD: wb_select = load;
      WB_LUI:  wb_select = lui;
      default: wb_select = link;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// EX/MEM latch inputs, data-cache port and MEM/WB outputs of the memory-access stage.
interface mem_access_if #(parameter int unsigned CNT_W = 16);
  import cpu_types_pkg::*;

  logic              valid_in;
  logic              dREN_in;
  logic              dWEN_in;
  logic [WORD_W-1:0] addr_in;
  logic [WORD_W-1:0] dmemstore_in;
  logic              regWr_in;
  logic [REG_W-1:0]  RegDst_in;
  wbsel_t            MemToReg_in;
  logic [WORD_W-1:0] luiValue_in;
  logic [WORD_W-1:0] pcp4_in;
  logic              halt_in;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;

  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              mem_stall;
  logic              wb_valid;
  logic              wb_regWr;
  logic [REG_W-1:0]  wb_RegDst;
  logic [WORD_W-1:0] wb_data;
  logic              halted;
  logic [CNT_W-1:0]  wait_cnt;

  // Pipeline / cache side
  modport master (
    output valid_in, dREN_in, dWEN_in, addr_in, dmemstore_in, regWr_in, RegDst_in,
           MemToReg_in, luiValue_in, pcp4_in, halt_in, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, wb_valid, wb_regWr,
           wb_RegDst, wb_data, halted, wait_cnt
  );

  // MEM stage side
  modport slave (
    input  valid_in, dREN_in, dWEN_in, addr_in, dmemstore_in, regWr_in, RegDst_in,
           MemToReg_in, luiValue_in, pcp4_in, halt_in, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, wb_valid, wb_regWr,
           wb_RegDst, wb_data, halted, wait_cnt
  );

endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: issues data-cache requests, stalls the pipe on a miss and
// registers the MEM/WB writeback bundle. Cache request and stall are combinational.
module mem_access
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic         CLK,
  input logic         nRST,
  mem_access_if.slave bus
);

  memstate_t         r_state;
  mem_req_t          r_req;
  logic              r_wb_valid;
  logic              r_wb_regWr;
  logic [REG_W-1:0]  r_wb_RegDst;
  logic [WORD_W-1:0] r_wb_data;
  logic              r_halted;
  logic [CNT_W-1:0]  r_wait_cnt;

  memstate_t         w_state_nxt;
  mem_req_t          w_req_nxt;
  mem_req_t          w_cur;
  mem_req_t          w_src;
  logic              w_mem_op;
  logic              w_done;
  logic              w_wait_inc;
  logic              w_wb_valid_nxt;
  logic              w_wb_regWr_nxt;
  logic [REG_W-1:0]  w_wb_RegDst_nxt;
  logic [WORD_W-1:0] w_wb_data_nxt;
  logic              w_halted_nxt;
  logic [CNT_W-1:0]  w_wait_nxt;
  logic              w_dmemREN;
  logic              w_dmemWEN;
  logic [WORD_W-1:0] w_dmemaddr;
  logic [WORD_W-1:0] w_dmemstore;
  logic              w_mem_stall;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_regWr  <= 1'b0;
      r_wb_RegDst <= '0;
      r_wb_data   <= '0;
      r_halted    <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_wb_valid  <= w_wb_valid_nxt;
      r_wb_regWr  <= w_wb_regWr_nxt;
      r_wb_RegDst <= w_wb_RegDst_nxt;
      r_wb_data   <= w_wb_data_nxt;
      r_halted    <= w_halted_nxt;
      r_wait_cnt  <= w_wait_nxt;
    end
  end

  always_comb begin
    // A request with both dREN and dWEN set is a store
    w_cur.is_store = bus.dWEN_in;
    w_cur.regwr    = bus.regWr_in;
    w_cur.regdst   = bus.RegDst_in;
    w_cur.memtoreg = bus.MemToReg_in;
    w_cur.addr     = bus.addr_in;
    w_cur.store    = bus.dmemstore_in;
    w_cur.lui      = bus.luiValue_in;
    w_cur.pcp4     = bus.pcp4_in;
    w_mem_op       = bus.valid_in & (bus.dREN_in | bus.dWEN_in);

    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_src        = w_cur;
    w_done       = 1'b0;
    w_wait_inc   = 1'b0;
    w_halted_nxt = r_halted;
    w_dmemREN    = 1'b0;
    w_dmemWEN    = 1'b0;
    w_dmemaddr   = '0;
    w_dmemstore  = '0;
    w_mem_stall  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.valid_in && bus.halt_in) begin
          w_state_nxt  = HALTED;
          w_halted_nxt = 1'b1;
        end else if (w_mem_op) begin
          w_dmemREN   = !w_cur.is_store;
          w_dmemWEN   = w_cur.is_store;
          w_dmemaddr  = w_cur.addr;
          w_dmemstore = w_cur.store;
          if (bus.dhit) begin
            w_done = 1'b1;
          end else begin
            w_mem_stall = 1'b1;
            w_wait_inc  = 1'b1;
            w_req_nxt   = w_cur;
            w_state_nxt = ACCESS;
          end
        end else if (bus.valid_in) begin
          w_done = 1'b1;
        end
      end
      ACCESS: begin
        // Upstream is frozen; only the latched copy is trusted
        w_src       = r_req;
        w_dmemREN   = !r_req.is_store;
        w_dmemWEN   = r_req.is_store;
        w_dmemaddr  = r_req.addr;
        w_dmemstore = r_req.store;
        w_mem_stall = !bus.dhit;
        if (bus.dhit) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      HALTED: begin
        w_mem_stall = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_wb_valid_nxt  = w_done;
    w_wb_regWr_nxt  = w_done & w_src.regwr & !w_src.is_store;
    w_wb_RegDst_nxt = w_done ? w_src.regdst : r_wb_RegDst;
    w_wb_data_nxt   = w_done ? wb_select(w_src.memtoreg, w_src.addr, bus.dmemload,
                                         w_src.lui, w_src.pcp4)
                             : r_wb_data;
    // Counts every cycle a request waits on the cache; sticks at all-ones
    w_wait_nxt = (w_wait_inc && (r_wait_cnt != '1)) ? r_wait_cnt + CNT_W'(1) : r_wait_cnt;

    if (!nRST) begin
      w_dmemREN   = 1'b0;
      w_dmemWEN   = 1'b0;
      w_dmemaddr  = '0;
      w_dmemstore = '0;
      w_mem_stall = 1'b0;
    end
  end

  assign bus.dmemREN   = w_dmemREN;
  assign bus.dmemWEN   = w_dmemWEN;
  assign bus.dmemaddr  = w_dmemaddr;
  assign bus.dmemstore = w_dmemstore;
  assign bus.mem_stall = w_mem_stall;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_regWr  = r_wb_regWr;
  assign bus.wb_RegDst = r_wb_RegDst;
  assign bus.wb_data   = r_wb_data;
  assign bus.halted    = r_halted;
  assign bus.wait_cnt  = r_wait_cnt;

endmodule

// File: tb/tb_mem_access.sv
// Directed plus randomized bench for mem_access against a per-instruction transaction model.
module tb_mem_access;
  import cpu_types_pkg::*;

  typedef struct {
    bit          valid;
    bit          ren;
    bit          wen;
    bit          regwr;
    bit          halt;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] lui;
    logic [31:0] pcp4;
    logic [4:0]  dst;
    wbsel_t      mtr;
  } ins_t;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  mem_access_if #(.CNT_W(16)) bus ();
  mem_access_if #(.CNT_W(4))  bus4 ();

  mem_access #(.CNT_W(16)) dut  (.CLK(CLK), .nRST(nRST), .bus(bus));
  mem_access #(.CNT_W(4))  dut4 (.CLK(CLK), .nRST(nRST), .bus(bus4));

  int total = 0;
  int bad   = 0;
  int exp_wait = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic ins_t mk(bit valid, bit ren, bit wen, bit regwr, bit halt,
                              logic [31:0] addr, logic [31:0] st, logic [4:0] dst,
                              wbsel_t mtr, logic [31:0] lui, logic [31:0] pcp4);
    ins_t i;
    i.valid = valid; i.ren = ren; i.wen = wen; i.regwr = regwr; i.halt = halt;
    i.addr = addr; i.st = st; i.dst = dst; i.mtr = mtr; i.lui = lui; i.pcp4 = pcp4;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    i = mk(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
           $urandom, $urandom, 5'($urandom), wbsel_t'(2'($urandom_range(0, 3))),
           $urandom, $urandom);
    return i;
  endfunction

  task automatic drive(input ins_t i);
    bus.valid_in     = i.valid;
    bus.dREN_in      = i.ren;
    bus.dWEN_in      = i.wen;
    bus.addr_in      = i.addr;
    bus.dmemstore_in = i.st;
    bus.regWr_in     = i.regwr;
    bus.RegDst_in    = i.dst;
    bus.MemToReg_in  = i.mtr;
    bus.luiValue_in  = i.lui;
    bus.pcp4_in      = i.pcp4;
    bus.halt_in      = i.halt;
  endtask

  function automatic logic [31:0] exp_wb(input ins_t i, input logic [31:0] load);
    case (i.mtr)
      WB_ALU:  return i.addr;
      WB_LOAD: return load;
      WB_LUI:  return i.lui;
      default: return i.pcp4;
    endcase
  endfunction

  // One instruction through MEM: lat stall cycles before the hit, then completion.
  task automatic run(input string tag, input ins_t i, input int lat_in, input logic [31:0] load);
    bit memop;
    int lat;
    ins_t junk;
    memop = i.valid && (i.ren || i.wen);
    lat   = memop ? lat_in : 0;
    for (int c = 0; c <= lat; c++) begin
      if (c == 0) drive(i);
      else begin
        junk = rnd_ins();
        junk.halt = 1'($urandom);
        drive(junk);
      end
      bus.dhit     = memop ? (c == lat) : 1'($urandom);
      bus.dmemload = (c == lat) ? load : $urandom;
      #1;
      chk({tag, ".stall"}, 32'(bus.mem_stall), 32'(memop && (c < lat)));
      chk({tag, ".ren"}, 32'(bus.dmemREN), 32'(memop && !i.wen));
      chk({tag, ".wen"}, 32'(bus.dmemWEN), 32'(memop && i.wen));
      if (memop) begin
        chk({tag, ".addr"}, bus.dmemaddr, i.addr);
        if (i.wen) chk({tag, ".sdata"}, bus.dmemstore, i.st);
      end
      tick();
      if (c < lat) begin
        exp_wait++;
        chk({tag, ".wbv_wait"}, 32'(bus.wb_valid), 32'd0);
      end
    end
    chk({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'(i.valid));
    chk({tag, ".wb_regWr"}, 32'(bus.wb_regWr), 32'(i.valid && i.regwr && !(memop && i.wen)));
    if (i.valid) begin
      chk({tag, ".wb_RegDst"}, 32'(bus.wb_RegDst), 32'(i.dst));
      chk({tag, ".wb_data"}, bus.wb_data, exp_wb(i, load));
    end
    chk({tag, ".wait_cnt"}, 32'(bus.wait_cnt), 32'(exp_wait));
  endtask

  initial begin
    ins_t i;
    ins_t bubble;
    bubble = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, WB_ALU, '0, '0);

    // Reset with a live load presented: everything must read zero
    nRST = 1'b0;
    drive(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 5'd3, WB_LOAD, 32'h0, 32'h0));
    bus.dhit = 1'b0; bus.dmemload = '0;
    bus4.valid_in = 1'b0; bus4.dREN_in = 1'b0; bus4.dWEN_in = 1'b0; bus4.addr_in = '0;
    bus4.dmemstore_in = '0; bus4.regWr_in = 1'b0; bus4.RegDst_in = '0;
    bus4.MemToReg_in = WB_ALU; bus4.luiValue_in = '0; bus4.pcp4_in = '0;
    bus4.halt_in = 1'b0; bus4.dhit = 1'b0; bus4.dmemload = '0;
    #2;
    chk("rst.ren", 32'(bus.dmemREN), 32'd0);
    chk("rst.stall", 32'(bus.mem_stall), 32'd0);
    chk("rst.addr", bus.dmemaddr, 32'd0);
    tick(); tick();
    chk("rst.wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst.wb_data", bus.wb_data, 32'd0);
    chk("rst.halted", 32'(bus.halted), 32'd0);
    chk("rst.wait_cnt", 32'(bus.wait_cnt), 32'd0);
    nRST = 1'b1;
    drive(bubble);
    tick();

    // Load hitting in the same cycle
    run("ld_hit", mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 5'd5, WB_LOAD, 32'h0, 32'h0),
        0, 32'hDEAD_BEEF);
    // Store with three stalled cycles while upstream inputs churn
    run("st_miss", mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h1234_5678, 5'd9, WB_ALU, 32'h0, 32'h0),
        3, 32'h0);
    // JAL link writeback, no cache traffic
    run("jal", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 5'd31, WB_LINK, 32'h0, 32'h104),
        0, 32'h0);
    // Both enables set behaves as a store
    run("rw_both", mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'hCAFE_0001, 5'd7, WB_LOAD, 32'h0, 32'h0),
        1, 32'h1111_2222);

    for (int n = 0; n < 150; n++) begin
      run("rand", rnd_ins(), int'($urandom_range(0, 3)), $urandom);
    end

    // Counter saturation on the narrow instance
    bus4.valid_in = 1'b1; bus4.dREN_in = 1'b1; bus4.addr_in = 32'h300;
    bus4.regWr_in = 1'b1; bus4.RegDst_in = 5'd2; bus4.MemToReg_in = WB_LOAD;
    for (int n = 1; n <= 20; n++) begin
      #1;
      chk("sat.stall", 32'(bus4.mem_stall), 32'd1);
      tick();
      if (n == 10 || n == 20) chk("sat.cnt", 32'(bus4.wait_cnt), 32'((n > 15) ? 15 : n));
      bus4.addr_in = $urandom;
    end
    bus4.dhit = 1'b1; bus4.dmemload = 32'hA5A5_0F0F;
    #1;
    chk("sat.hit_stall", 32'(bus4.mem_stall), 32'd0);
    chk("sat.hold_addr", bus4.dmemaddr, 32'h300);
    tick();
    chk("sat.wb_data", bus4.wb_data, 32'hA5A5_0F0F);
    chk("sat.cnt_end", 32'(bus4.wait_cnt), 32'd15);
    bus4.valid_in = 1'b0; bus4.dhit = 1'b0;

    // Reset in the middle of an outstanding store
    drive(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h77, 5'd1, WB_ALU, 32'h0, 32'h0));
    bus.dhit = 1'b0;
    tick(); tick();
    nRST = 1'b0;
    #1;
    chk("mid_rst.wen", 32'(bus.dmemWEN), 32'd0);
    chk("mid_rst.ren", 32'(bus.dmemREN), 32'd0);
    chk("mid_rst.stall", 32'(bus.mem_stall), 32'd0);
    chk("mid_rst.cnt", 32'(bus.wait_cnt), 32'd0);
    tick();
    nRST = 1'b1;
    exp_wait = 0;
    drive(bubble);
    bus.dhit = 1'b1;
    #1;
    chk("post_rst.wen", 32'(bus.dmemWEN), 32'd0);
    chk("post_rst.stall", 32'(bus.mem_stall), 32'd0);
    tick();
    chk("post_rst.wbv", 32'(bus.wb_valid), 32'd0);
    chk("post_rst.cnt", 32'(bus.wait_cnt), 32'd0);
    run("post_rst_alu", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h9, 32'h0, 5'd4, WB_LUI, 32'hABCD_0000, 32'h0),
        0, 32'h0);

    // HALT with a load flag set, then more loads
    drive(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 32'h0, 5'd6, WB_LOAD, 32'h0, 32'h0));
    bus.dhit = 1'b0;
    #1;
    chk("halt.ren", 32'(bus.dmemREN), 32'd0);
    tick();
    chk("halt.halted", 32'(bus.halted), 32'd1);
    chk("halt.wbv", 32'(bus.wb_valid), 32'd0);
    for (int n = 0; n < 5; n++) begin
      drive(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, $urandom, 32'h0, 5'd8, WB_LOAD, 32'h0, 32'h0));
      bus.dhit = 1'($urandom);
      #1;
      chk("halted.ren", 32'(bus.dmemREN), 32'd0);
      chk("halted.stall", 32'(bus.mem_stall), 32'd1);
      tick();
      chk("halted.wbv", 32'(bus.wb_valid), 32'd0);
      chk("halted.flag", 32'(bus.halted), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
